// File: rtl/sensor_debouncer.sv
// Two-channel optical sensor conditioner: double-flop synchronizer, per-channel
// stability debounce, one-cycle change strobe and saturating bounce counter.
module sensor_debouncer #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       D1_raw,
    input  logic       D2_raw,
    output logic       D1,
    output logic       D2,
    output logic       Chg,
    output logic [7:0] Glitch
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Adds 0..2 rejected bounces to the diagnostic count, clamping at 255.
    function automatic logic [7:0] glitch_add(input logic [7:0] acc, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, acc} + {7'd0, n};
        if (sum > 9'd255) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          s_q, s_d;
    logic [1:0]          d_q, d_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic                chg_q, chg_d;
    logic [7:0]          glitch_q, glitch_d;
    logic [1:0]          acc_s;
    logic [1:0]          rej_s;

    // Next-state: synchronizer shift, per-channel debounce decision, strobe and counter.
    always_comb begin
        sync1_d = {D2_raw, D1_raw};
        s_d     = sync1_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        acc_s   = 2'b00;
        rej_s   = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (s_q[ch] == d_q[ch]) begin
                // Sample fell back to the accepted level before the count completed.
                if (cnt_q[ch] != CNT_ZERO) begin
                    cnt_d[ch] = CNT_ZERO;
                    rej_s[ch] = 1'b1;
                end else begin
                    cnt_d[ch] = cnt_q[ch];
                end
            end else if (cnt_q[ch] == CNT_LAST) begin
                d_d[ch]   = s_q[ch];
                cnt_d[ch] = CNT_ZERO;
                acc_s[ch] = 1'b1;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
        end
        chg_d    = |acc_s;
        glitch_d = glitch_add(glitch_q, {1'b0, rej_s[0]} + {1'b0, rej_s[1]});
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q  <= 2'b00;
            s_q      <= 2'b00;
            d_q      <= 2'b00;
            cnt_q    <= {2{CNT_ZERO}};
            chg_q    <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            sync1_q  <= sync1_d;
            s_q      <= s_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            glitch_q <= glitch_d;
        end
    end

    assign D1     = d_q[0];
    assign D2     = d_q[1];
    assign Chg    = chg_q;
    assign Glitch = glitch_q;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Bench for sensor_debouncer: STABLE_CYCLES=4 and =1 instances share stimulus and
// are checked against constant tables, hand sequences and a sample-history model.
module tb_sensor_debouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, d1_raw, d2_raw;
    logic       a_d1, a_d2, a_chg;
    logic [7:0] a_glitch;
    logic       b_d1, b_d2, b_chg;
    logic [7:0] b_glitch;

    sensor_debouncer #(.STABLE_CYCLES(4)) u4 (
        .Clk(clk), .Rst(rst), .D1_raw(d1_raw), .D2_raw(d2_raw),
        .D1(a_d1), .D2(a_d2), .Chg(a_chg), .Glitch(a_glitch)
    );

    sensor_debouncer #(.STABLE_CYCLES(1)) u1 (
        .Clk(clk), .Rst(rst), .D1_raw(d1_raw), .D2_raw(d2_raw),
        .D1(b_d1), .D2(b_d2), .Chg(b_chg), .Glitch(b_glitch)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: index 0 = STABLE 4 instance, 1 = STABLE 1 instance.
    // A level is accepted once the last STABLE synchronized samples all differ from it;
    // a bounce is a sample equal to the accepted level right after one that differed.
    int   stab [2] = '{4, 1};
    logic m_pipe [2][2][2];
    logic m_hist [2][2][5];
    logic m_d    [2][2];
    logic m_chg  [2];
    int   m_glitch [2];

    task automatic model_reset(input int i);
        for (int c = 0; c < 2; c++) begin
            m_pipe[i][c][0] = 1'b0;
            m_pipe[i][c][1] = 1'b0;
            for (int k = 0; k < 5; k++) m_hist[i][c][k] = 1'b0;
            m_d[i][c] = 1'b0;
        end
        m_chg[i]    = 1'b0;
        m_glitch[i] = 0;
    endtask

    task automatic model_step(input logic r, input logic raw0, input logic raw1);
        int   rej;
        logic acc;
        logic cur;
        logic all_diff;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                model_reset(i);
            end else begin
                rej = 0;
                acc = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    cur = m_pipe[i][c][1];
                    for (int k = 4; k > 0; k--) m_hist[i][c][k] = m_hist[i][c][k-1];
                    m_hist[i][c][0] = cur;
                    all_diff = 1'b1;
                    for (int k = 0; k < stab[i]; k++)
                        if (m_hist[i][c][k] == m_d[i][c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_d[i][c] = cur;
                        acc = 1'b1;
                    end else if (cur == m_d[i][c] && m_hist[i][c][1] != m_d[i][c]) begin
                        rej++;
                    end
                    m_pipe[i][c][1] = m_pipe[i][c][0];
                    m_pipe[i][c][0] = (c == 0) ? raw0 : raw1;
                end
                m_chg[i] = acc;
                m_glitch[i] = (m_glitch[i] + rej > 255) ? 255 : m_glitch[i] + rej;
            end
        end
    endtask

    // One clock: advance model with the inputs present at the edge, then compare after it.
    task automatic tick();
        logic r, x1, x2;
        r  = rst;
        x1 = d1_raw;
        x2 = d2_raw;
        @(posedge clk);
        model_step(r, x1, x2);
        #1;
        chk("m4_d1", a_d1, m_d[0][0]);
        chk("m4_d2", a_d2, m_d[0][1]);
        chk("m4_chg", a_chg, m_chg[0]);
        chk("m4_glitch", a_glitch, m_glitch[0]);
        chk("m1_d1", b_d1, m_d[1][0]);
        chk("m1_d2", b_d2, m_d[1][1]);
        chk("m1_chg", b_chg, m_chg[1]);
        chk("m1_glitch", b_glitch, m_glitch[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        d1_raw = 1'b0;
        d2_raw = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        logic       rst;
        logic       r1;
        logic       r2;
        logic       e_d1;
        logic       e_d2;
        logic       e_chg;
        logic [7:0] e_g;
    } vec_t;

    vec_t tbl [18];
    int   h1, h2, l1, l2;

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
        rst = 1'b1; d1_raw = 1'b1; d2_raw = 1'b1;

        // Reset with garbage, clean step on D1 (accept at edge 5), bounce on D2.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; d1_raw = tbl[i].r1; d2_raw = tbl[i].r2;
            tick();
            chk($sformatf("tbl%0d_d1", i), a_d1, tbl[i].e_d1);
            chk($sformatf("tbl%0d_d2", i), a_d2, tbl[i].e_d2);
            chk($sformatf("tbl%0d_chg", i), a_chg, tbl[i].e_chg);
            chk($sformatf("tbl%0d_glitch", i), a_glitch, tbl[i].e_g);
        end

        // Simultaneous rise then fall: one Chg pulse per change, STABLE=1 at edge 2.
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            d1_raw = (ph == 0); d2_raw = (ph == 0);
            for (int e = 0; e < 8; e++) begin
                tick();
                chk($sformatf("sim%0d_e%0d_a_d1", ph, e), a_d1, (e >= 5) == (ph == 0));
                chk($sformatf("sim%0d_e%0d_a_d2", ph, e), a_d2, (e >= 5) == (ph == 0));
                chk($sformatf("sim%0d_e%0d_a_chg", ph, e), a_chg, e == 5);
                chk($sformatf("sim%0d_e%0d_b_d1", ph, e), b_d1, (e >= 2) == (ph == 0));
                chk($sformatf("sim%0d_e%0d_b_chg", ph, e), b_chg, e == 2);
            end
        end

        // Reset asserted at edge 3 of a pending rise, released for edge 4.
        do_reset();
        d1_raw = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rmid_e3_a_d1", a_d1, 1'b0);
        chk("rmid_e3_b_d1", b_d1, 1'b0);
        rst = 1'b0;
        for (int e = 4; e < 12; e++) begin
            tick();
            chk($sformatf("rmid_e%0d_a_d1", e), a_d1, e >= 9);
            chk($sformatf("rmid_e%0d_a_chg", e), a_chg, e == 9);
            chk($sformatf("rmid_e%0d_b_d1", e), b_d1, e >= 6);
            chk($sformatf("rmid_e%0d_b_chg", e), b_chg, e == 6);
        end

        // Glitch saturation: 300 in-phase 3-cycle pulses on both lines.
        do_reset();
        for (int p = 1; p <= 300; p++) begin
            d1_raw = 1'b1; d2_raw = 1'b1;
            tick(); tick(); tick();
            d1_raw = 1'b0; d2_raw = 1'b0;
            tick(); tick(); tick();
            if (p == 100 || p == 127 || p == 128 || p == 300) begin
                chk($sformatf("sat_p%0d_glitch", p), a_glitch, (2 * p > 255) ? 255 : 2 * p);
                chk($sformatf("sat_p%0d_d1", p), a_d1, 1'b0);
                chk($sformatf("sat_p%0d_d2", p), a_d2, 1'b0);
            end
        end
        chk("sat_b_glitch", b_glitch, 8'd0);

        // Random held runs with occasional reset, checked by the model on every edge.
        do_reset();
        h1 = 0; h2 = 0; l1 = 0; l2 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (h1 == 0) begin l1 = $urandom_range(0, 1); h1 = $urandom_range(1, 7); end
            if (h2 == 0) begin l2 = $urandom_range(0, 1); h2 = $urandom_range(1, 7); end
            h1--; h2--;
            d1_raw = l1[0];
            d2_raw = l2[0];
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
